// File: rtl/fir_stream_engine.sv
// fir_stream_engine: configurable-tap streaming FIR with job control, rounding/saturating scaling and optional history retention.
module fir_stream_engine #(
  parameter int NTAPS   = 8,
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int LEN_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     clear_hist_i,
  input  logic [4:0]               shift_i,
  input  logic [NTAPS*COEFF_W-1:0] coeff_i,
  input  logic [DATA_W-1:0]        a_data_i,
  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  output logic [DATA_W-1:0]        b_data_o,
  output logic                     b_valid_o,
  input  logic                     b_ready_i,
  output logic                     busy_o,
  output logic                     idle_o,
  output logic                     done_o,
  output logic [LEN_W-1:0]         cnt_o
);
  localparam int ACC_W = DATA_W + COEFF_W + $clog2(NTAPS);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [LEN_W-1:0] len_q, in_cnt;
  logic [4:0] shift_q;
  logic signed [COEFF_W-1:0] coef_q [NTAPS];
  logic signed [DATA_W-1:0] hist [NTAPS-1];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0] rnd, r;
  logic signed [DATA_W-1:0] y;
  logic a_hs, b_hs;
  assign a_ready_o = (state == RUN) && (!b_valid_o || b_ready_i);
  assign a_hs = a_valid_i && a_ready_o;
  assign b_hs = b_valid_o && b_ready_i;
  assign busy_o = (state == RUN) || (state == DRAIN);
  assign idle_o = state == IDLE;
  assign done_o = state == DONE;
  // One guard bit above the accumulator keeps the rounding add from wrapping at large shifts.
  always_comb begin
    acc = ACC_W'(coef_q[0]) * ACC_W'($signed(a_data_i));
    for (int k = 1; k < NTAPS; k++) acc = acc + ACC_W'(coef_q[k]) * ACC_W'(hist[k-1]);
    rnd = shift_q == 5'd0 ? '0 : (ACC_W+1)'(1) << (shift_q - 5'd1);
    r = ($signed({acc[ACC_W-1], acc}) + rnd) >>> shift_q;
    y = r > MAXV ? MAXV[DATA_W-1:0] : r < MINV ? MINV[DATA_W-1:0] : r[DATA_W-1:0];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      len_q <= '0;
      shift_q <= '0;
      in_cnt <= '0;
      cnt_o <= '0;
      b_data_o <= '0;
      b_valid_o <= 1'b0;
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= '0;
      for (int k = 0; k < NTAPS-1; k++) hist[k] <= '0;
    end else begin
      if (b_hs) cnt_o <= cnt_o + 1'b1;
      if (a_hs) begin
        b_data_o <= y;
        b_valid_o <= 1'b1;
        in_cnt <= in_cnt + 1'b1;
        hist[0] <= $signed(a_data_i);
        for (int k = 1; k < NTAPS-1; k++) hist[k] <= hist[k-1];
      end else if (b_hs) b_valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          len_q <= len_i;
          shift_q <= shift_i;
          in_cnt <= '0;
          cnt_o <= '0;
          for (int k = 0; k < NTAPS; k++) coef_q[k] <= coeff_i[k*COEFF_W +: COEFF_W];
          if (clear_hist_i) for (int k = 0; k < NTAPS-1; k++) hist[k] <= '0;
          state <= len_i != '0 ? RUN : DONE;
        end
        RUN: if (a_hs && in_cnt == len_q - 1'b1) state <= DRAIN;
        DRAIN: if (b_hs) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_stream_engine.sv
// tb_fir_stream_engine: randomized scenarios checked against a sample-history reference model.
module tb_fir_stream_engine;
  localparam int NTAPS = 8, DATA_W = 16, COEFF_W = 16, LEN_W = 16;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, clear_hist_i = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic [4:0] shift_i = '0;
  logic [NTAPS*COEFF_W-1:0] coeff_i = '0;
  logic [DATA_W-1:0] a_data_i = '0;
  logic a_valid_i = 1'b0, a_ready_o, b_valid_o, b_ready_i = 1'b0, busy_o, idle_o, done_o;
  logic signed [DATA_W-1:0] b_data_o;
  logic [LEN_W-1:0] cnt_o;
  int n_cmp = 0, n_err = 0;
  int c_m [NTAPS];
  int sh_m;
  int past[$], xin[$], got[$], exp_q[$];
  int stab_err, done_cnt, done_k, last_hs_k;
  bit aborted;
  logic idle_after, ready_k0;

  fir_stream_engine #(.NTAPS(NTAPS), .DATA_W(DATA_W), .COEFF_W(COEFF_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .clear_hist_i(clear_hist_i),
    .shift_i(shift_i), .coeff_i(coeff_i), .a_data_i(a_data_i), .a_valid_i(a_valid_i),
    .a_ready_o(a_ready_o), .b_data_o(b_data_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .busy_o(busy_o), .idle_o(idle_o), .done_o(done_o), .cnt_o(cnt_o));

  always #5 clk_i = ~clk_i;

  function automatic int ref_out(input int x);
    longint acc, r, maxv, minv;
    acc = longint'(c_m[0]) * x;
    for (int k = 1; k < NTAPS; k++) if (past.size() >= k) acc += longint'(c_m[k]) * past[past.size()-k];
    r = (acc + (sh_m > 0 ? (longint'(1) << (sh_m - 1)) : longint'(0))) >>> sh_m;
    maxv = (longint'(1) << (DATA_W - 1)) - 1;
    minv = -(longint'(1) << (DATA_W - 1));
    past.push_back(x);
    return int'(r > maxv ? maxv : r < minv ? minv : r);
  endfunction

  task automatic rand_cfg(input int sh);
    for (int i = 0; i < NTAPS; i++) c_m[i] = int'($signed(16'($urandom)));
    sh_m = sh;
  endtask

  task automatic rand_xin(input int n);
    xin.delete();
    for (int i = 0; i < n; i++) xin.push_back(int'($signed(16'($urandom))));
  endtask

  task automatic run_job(input int len, input bit clr, input int rdy_pct, input int pulse_k, input int abort_n);
    int sent;
    logic [DATA_W-1:0] held;
    bit hold;
    got.delete(); exp_q.delete();
    stab_err = 0; done_cnt = 0; done_k = -1; last_hs_k = -1; aborted = 0; sent = 0; hold = 0; held = '0;
    if (clr) past.delete();
    for (int i = 0; i < NTAPS; i++) coeff_i[i*COEFF_W +: COEFF_W] = COEFF_W'(c_m[i]);
    shift_i = 5'(sh_m); len_i = LEN_W'(len); clear_hist_i = clr; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; len_i = LEN_W'(3); clear_hist_i = 1'b1; shift_i = 5'($urandom);
    for (int i = 0; i < NTAPS; i++) coeff_i[i*COEFF_W +: COEFF_W] = COEFF_W'($urandom);
    for (int k = 0; k < 5000; k++) begin
      start_i = (k == pulse_k);
      a_valid_i = (sent < len) && ($urandom_range(0, 99) < 70);
      a_data_i = sent < len ? DATA_W'(xin[sent]) : '0;
      b_ready_i = $urandom_range(0, 99) < rdy_pct;
      @(negedge clk_i);
      if (hold && (!b_valid_o || b_data_o !== held)) stab_err++;
      hold = b_valid_o && !b_ready_i;
      held = b_data_o;
      if (k == 0) ready_k0 = a_ready_o;
      if (done_o) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (b_valid_o && b_ready_i) begin got.push_back(int'(b_data_o)); last_hs_k = k; end
      if (a_valid_i && a_ready_o) begin exp_q.push_back(ref_out(xin[sent])); sent++; end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (abort_n > 0 && got.size() == abort_n) begin aborted = 1; break; end
      if (done_k >= 0) break;
    end
    a_valid_i = 1'b0; b_ready_i = 1'b0;
    if (!aborted) begin
      @(negedge clk_i);
      idle_after = idle_o;
      if (done_o) done_cnt++;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if ({a_ready_o, b_valid_o, busy_o, idle_o, done_o} !== 5'b00010) begin n_err++; $display("FAIL reset_flags: got %b want 00010", {a_ready_o, b_valid_o, busy_o, idle_o, done_o}); end
    n_cmp++; if (b_data_o !== '0) begin n_err++; $display("FAIL reset_data: got %0d want 0", b_data_o); end
    n_cmp++; if (cnt_o !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt_o); end
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic test_impulse;
    for (int i = 0; i < NTAPS; i++) c_m[i] = i + 1;
    sh_m = 0;
    xin = '{1, 0, 0, 0, 0, 0, 0, 0};
    run_job(8, 1, 100, -1, 0);
    n_cmp++; if (ready_k0 !== 1'b1) begin n_err++; $display("FAIL impulse_start_latency: a_ready %b want 1", ready_k0); end
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL impulse_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_cmp++; if (got[i] !== i + 1) begin n_err++; $display("FAIL impulse_out[%0d]: got %0d want %0d", i, got[i], i + 1); end
    end
    n_cmp++; if (done_k !== last_hs_k + 1) begin n_err++; $display("FAIL impulse_done_time: got %0d want %0d", done_k, last_hs_k + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL impulse_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (idle_after !== 1'b1) begin n_err++; $display("FAIL impulse_idle_after: got %b want 1", idle_after); end
    n_cmp++; if (cnt_o !== LEN_W'(8)) begin n_err++; $display("FAIL impulse_cnt: got %0d want 8", cnt_o); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < NTAPS; i++) c_m[i] = 32767;
    sh_m = 0;
    xin.delete(); repeat (8) xin.push_back(32767);
    run_job(8, 1, 100, -1, 0);
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL sat_pos_count: got %0d want 8", got.size()); end
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== 32767) begin n_err++; $display("FAIL sat_pos[%0d]: got %0d want 32767", i, got[i]); end
    end
    xin.delete(); repeat (8) xin.push_back(-32768);
    run_job(8, 1, 100, -1, 0);
    foreach (got[i]) begin
      n_cmp++; if (got[i] !== -32768) begin n_err++; $display("FAIL sat_neg[%0d]: got %0d want -32768", i, got[i]); end
    end
    for (int i = 0; i < NTAPS; i++) c_m[i] = 0;
    c_m[0] = 3; sh_m = 1;
    xin = '{1};
    run_job(1, 1, 100, -1, 0);
    n_cmp++; if (got.size() !== 1 || got[0] !== 2) begin n_err++; $display("FAIL round_up: got %0d want 2", got.size() > 0 ? got[0] : -999); end
    xin = '{-1};
    run_job(1, 1, 100, -1, 0);
    n_cmp++; if (got.size() !== 1 || got[0] !== -1) begin n_err++; $display("FAIL round_neg: got %0d want -1", got.size() > 0 ? got[0] : -999); end
  endtask

  task automatic test_backpressure;
    rand_cfg($urandom_range(14, 20));
    rand_xin(100);
    run_job(100, 1, 50, -1, 0);
    n_cmp++; if (got.size() !== 100 || exp_q.size() !== 100) begin n_err++; $display("FAIL bp_count: got %0d outputs, %0d inputs, want 100", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_out[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL bp_stall_stable: %0d changes while stalled, want 0", stab_err); end
    n_cmp++; if (done_k !== last_hs_k + 1 || done_cnt !== 1) begin n_err++; $display("FAIL bp_done: at %0d x%0d want at %0d x1", done_k, done_cnt, last_hs_k + 1); end
    n_cmp++; if (cnt_o !== LEN_W'(100)) begin n_err++; $display("FAIL bp_cnt: got %0d want 100", cnt_o); end
  endtask

  task automatic test_history;
    int full[$], ref8[$], reff[$];
    rand_cfg(16);
    rand_xin(8);
    full = xin;
    run_job(8, 1, 100, -1, 0);
    ref8 = got;
    xin = full[4:7];
    run_job(4, 1, 100, -1, 0);
    reff = got;
    xin = full[0:3];
    run_job(4, 1, 100, -1, 0);
    xin = full[4:7];
    run_job(4, 0, 100, -1, 0);
    n_cmp++; if (got.size() !== 4 || ref8.size() !== 8) begin n_err++; $display("FAIL hist_keep_count: got %0d/%0d want 4/8", got.size(), ref8.size()); end
    for (int i = 0; i < got.size() && i + 4 < ref8.size(); i++) begin
      n_cmp++; if (got[i] !== ref8[i+4]) begin n_err++; $display("FAIL hist_keep[%0d]: got %0d want %0d", i, got[i], ref8[i+4]); end
      n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL hist_keep_model[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
    xin = full[0:3];
    run_job(4, 1, 100, -1, 0);
    xin = full[4:7];
    run_job(4, 1, 100, -1, 0);
    n_cmp++; if (got.size() !== reff.size()) begin n_err++; $display("FAIL hist_clear_count: got %0d want %0d", got.size(), reff.size()); end
    for (int i = 0; i < got.size() && i < reff.size(); i++) begin
      n_cmp++; if (got[i] !== reff[i]) begin n_err++; $display("FAIL hist_clear[%0d]: got %0d want %0d", i, got[i], reff[i]); end
    end
  endtask

  task automatic test_edge;
    rand_cfg(15);
    xin.delete();
    run_job(0, 0, 100, -1, 0);
    n_cmp++; if (done_k !== 0) begin n_err++; $display("FAIL len0_done_time: got %0d want 0", done_k); end
    n_cmp++; if (got.size() !== 0 || done_cnt !== 1) begin n_err++; $display("FAIL len0_traffic: got %0d outputs %0d dones want 0/1", got.size(), done_cnt); end
    n_cmp++; if (cnt_o !== '0) begin n_err++; $display("FAIL len0_cnt: got %0d want 0", cnt_o); end
    rand_xin(10);
    run_job(10, 1, 80, 2, 0);
    n_cmp++; if (got.size() !== 10 || cnt_o !== LEN_W'(10)) begin n_err++; $display("FAIL start_ignored_len: got %0d outputs cnt %0d want 10", got.size(), cnt_o); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL start_ignored_out[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    rand_cfg(15);
    rand_xin(10);
    run_job(10, 1, 100, -1, 3);
    n_cmp++; if (aborted !== 1'b1) begin n_err++; $display("FAIL midrst_reach: aborted %b want 1", aborted); end
    rst_i = 1'b1;
    #1;
    n_cmp++; if ({a_ready_o, b_valid_o, busy_o, idle_o, done_o} !== 5'b00010) begin n_err++; $display("FAIL midrst_flags: got %b want 00010", {a_ready_o, b_valid_o, busy_o, idle_o, done_o}); end
    n_cmp++; if (b_data_o !== '0 || cnt_o !== '0) begin n_err++; $display("FAIL midrst_data_cnt: got %0d/%0d want 0/0", b_data_o, cnt_o); end
    dones = 0;
    repeat (3) begin @(negedge clk_i); if (done_o) dones++; end
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (3) begin @(negedge clk_i); if (done_o) dones++; end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    past.delete();
    rand_cfg(15);
    rand_xin(8);
    run_job(8, 0, 100, -1, 0);
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL postrst_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL postrst_out[%0d]: got %0d want %0d", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_history();
    test_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
